// File: rtl/roulette_pkg.sv
// roulette_pkg: shared types and constants for the roulette engine slice.
// Holds the game state enum, the bet mode enum, the streak bonus amount
// and the Galois LFSR feedback mask.
package roulette_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BET    = 3'd1,
        ST_SPIN   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WON    = 3'd4,
        ST_LOST   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_EVEN  = 2'd1,
        MODE_ODD   = 2'd2,
        MODE_RSVD  = 2'd3
    } bet_mode_t;

    // Extra credit paid on the third consecutive win
    localparam int STREAK_BONUS = 5;

    // Right-shifting Galois mask for taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/roulette_if.sv
// roulette_if: bet/result bus between the input debounce logic (master)
// and the roulette engine (slave). Clock and reset are kept outside.
interface roulette_if #(
    parameter int NUM_W = 5,
    parameter int AMT_W = 4,
    parameter int BAL_W = 8
);

    logic             start;
    logic             abort;
    logic             bet_valid;
    logic             bet_ready;
    logic [1:0]       bet_mode;
    logic [NUM_W-1:0] bet_guess;
    logic [AMT_W-1:0] bet_amt;
    logic             ext_num_en;
    logic [NUM_W-1:0] ext_num;
    logic             bet_err;
    logic             result_valid;
    logic [NUM_W-1:0] result_num;
    logic             result_win;
    logic [BAL_W-1:0] balance;
    logic             game_won;
    logic             game_lost;
    logic [1:0]       streak;

    modport master (
        output start, abort, bet_valid, bet_mode, bet_guess, bet_amt,
               ext_num_en, ext_num,
        input  bet_ready, bet_err, result_valid, result_num, result_win,
               balance, game_won, game_lost, streak
    );

    modport slave (
        input  start, abort, bet_valid, bet_mode, bet_guess, bet_amt,
               ext_num_en, ext_num,
        output bet_ready, bet_err, result_valid, result_num, result_win,
               balance, game_won, game_lost, streak
    );

endinterface

// File: rtl/roulette_lfsr.sv
// roulette_lfsr: free-running 16-bit Galois LFSR, loaded with SEED on reset.
// Only the low OUT_W bits are exported as the raw wheel candidate.
module roulette_lfsr
    import roulette_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [OUT_W-1:0] o_value
);

    logic [15:0] r_state;
    logic [15:0] w_next;

    // Shift right and fold the feedback mask in when a one falls out
    always_comb begin
        w_next = {1'b0, r_state[15:1]};
        if (r_state[0]) begin
            w_next = w_next ^ LFSR_TAPS;
        end
    end

    // Step every cycle regardless of game state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_value = r_state[OUT_W-1:0];

endmodule

// File: rtl/roulette_engine.sv
// roulette_engine: takes bets over a valid/ready handshake, spins a number
// (LFSR or external) and settles the stake against the player balance.
// Optional feature macro: ROULETTE_STREAK_BONUS_EN adds a consecutive-win
// counter that pays STREAK_BONUS on every third win in a row.
module roulette_engine
    import roulette_pkg::*;
#(
    parameter int          NUM_MAX     = 31,
    parameter int          BAL_W       = 8,
    parameter int          AMT_W       = 4,
    parameter int          START_BAL   = 10,
    parameter int          WIN_BAL     = 20,
    parameter int          EXACT_PAY   = 4,
    parameter int          PARITY_PAY  = 1,
    parameter int          SPIN_CYCLES = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input logic      clk,
    input logic      reset_n,
    roulette_if.slave io_bus
);

    localparam int NUM_W = $clog2(NUM_MAX + 1);
    localparam int SUM_W = BAL_W + AMT_W + 3;
    localparam int CNT_W = $clog2(SPIN_CYCLES + 1);
    localparam logic [NUM_W-1:0] NUM_MAX_V = NUM_W'(NUM_MAX);
    localparam logic [SUM_W-1:0] BAL_MAX_V = SUM_W'((64'd1 << BAL_W) - 64'd1);

    state_t             r_state;
    state_t             w_nextState;
    bet_mode_t          r_betMode;
    logic [NUM_W-1:0]   r_betGuess;
    logic [AMT_W-1:0]   r_betAmt;
    logic [CNT_W-1:0]   r_spinCnt;
    logic [NUM_W-1:0]   r_spinNum;
    logic [BAL_W-1:0]   r_balance;
    logic [NUM_W-1:0]   r_resultNum;
    logic               r_resultWin;
    logic               r_resultValid;
    logic               r_betErr;

    bet_mode_t          w_mode;
    logic [NUM_W-1:0]   w_lfsrNum;
    logic [NUM_W-1:0]   w_candidate;
    logic               w_betOk;
    logic               w_betReady;
    logic               w_accept;
    logic               w_reject;
    logic               w_spinDone;
    logic               w_startGame;
    logic               w_win;
    logic [SUM_W-1:0]   w_payMul;
    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   w_bonus;
    logic [BAL_W-1:0]   w_newBalance;
    state_t             w_settleState;

    roulette_lfsr #(
        .SEED  (SEED),
        .OUT_W (NUM_W)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .o_value (w_lfsrNum)
    );

    assign w_mode      = bet_mode_t'(io_bus.bet_mode);
    assign w_candidate = io_bus.ext_num_en ? io_bus.ext_num : w_lfsrNum;

    // Bet legality: nonzero stake the player can cover, known mode, guess on the wheel
    always_comb begin
        w_betOk = 1'b1;
        if (io_bus.bet_amt == '0) begin
            w_betOk = 1'b0;
        end
        if ({{BAL_W{1'b0}}, io_bus.bet_amt} > {{AMT_W{1'b0}}, r_balance}) begin
            w_betOk = 1'b0;
        end
        if (w_mode == MODE_RSVD) begin
            w_betOk = 1'b0;
        end
        if ((w_mode == MODE_EXACT) && (io_bus.bet_guess > NUM_MAX_V)) begin
            w_betOk = 1'b0;
        end
    end

`ifdef ROULETTE_STREAK_BONUS_EN
    logic [1:0] r_streak;

    assign w_bonus = (r_streak == 2'd2) ? SUM_W'(STREAK_BONUS) : '0;

    // Count consecutive wins; the third in a row collects the bonus and restarts the count
    always_ff @(posedge clk) begin
        if (!reset_n || io_bus.abort) begin
            r_streak <= 2'd0;
        end else if (r_state == ST_SETTLE) begin
            if (w_win) begin
                r_streak <= (r_streak == 2'd2) ? 2'd0 : r_streak + 2'd1;
            end else begin
                r_streak <= 2'd0;
            end
        end
    end

    assign io_bus.streak = r_streak;
`else
    assign w_bonus       = '0;
    assign io_bus.streak = 2'd0;
`endif

    // Settlement: decide the outcome of the latched bet and the resulting balance
    always_comb begin
        w_win = 1'b0;
        case (r_betMode)
            MODE_EXACT: w_win = (r_betGuess == r_spinNum);
            MODE_EVEN:  w_win = (r_spinNum != '0) && !r_spinNum[0];
            MODE_ODD:   w_win = r_spinNum[0];
            default:    w_win = 1'b0;
        endcase
        w_payMul = (r_betMode == MODE_EXACT) ? SUM_W'(EXACT_PAY) : SUM_W'(PARITY_PAY);
        w_sum    = SUM_W'(r_balance) + (SUM_W'(r_betAmt) * w_payMul) + w_bonus;
        if (w_win) begin
            w_newBalance = (w_sum > BAL_MAX_V) ? BAL_MAX_V[BAL_W-1:0] : w_sum[BAL_W-1:0];
        end else begin
            w_newBalance = r_balance - BAL_W'(r_betAmt);
        end
        if (w_newBalance >= BAL_W'(WIN_BAL)) begin
            w_settleState = ST_WON;
        end else if (w_newBalance == '0) begin
            w_settleState = ST_LOST;
        end else begin
            w_settleState = ST_BET;
        end
    end

    // Game state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode; abort overrides everything else
    always_comb begin
        w_nextState = r_state;
        w_betReady  = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_spinDone  = 1'b0;
        w_startGame = 1'b0;
        case (r_state)
            ST_IDLE, ST_WON, ST_LOST: begin
                if (io_bus.start) begin
                    w_startGame = 1'b1;
                    w_nextState = ST_BET;
                end
            end
            ST_BET: begin
                w_betReady = !r_resultValid;
                if (io_bus.bet_valid && w_betReady) begin
                    if (w_betOk) begin
                        w_accept    = 1'b1;
                        w_nextState = ST_SPIN;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_SPIN: begin
                if ((r_spinCnt >= CNT_W'(SPIN_CYCLES)) && (w_candidate <= NUM_MAX_V)) begin
                    w_spinDone  = 1'b1;
                    w_nextState = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_nextState = w_settleState;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (io_bus.abort) begin
            w_nextState = ST_IDLE;
            w_accept    = 1'b0;
            w_reject    = 1'b0;
            w_spinDone  = 1'b0;
            w_startGame = 1'b0;
        end
    end

    // Bet latch, spin counter, balance and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_betMode     <= MODE_EXACT;
            r_betGuess    <= '0;
            r_betAmt      <= '0;
            r_spinCnt     <= '0;
            r_spinNum     <= '0;
            r_balance     <= '0;
            r_resultNum   <= '0;
            r_resultWin   <= 1'b0;
            r_resultValid <= 1'b0;
            r_betErr      <= 1'b0;
        end else begin
            r_resultValid <= 1'b0;
            r_betErr      <= w_reject;
            if (io_bus.abort) begin
                r_balance <= '0;
            end else begin
                if (w_startGame) begin
                    r_balance <= BAL_W'(START_BAL);
                end
                if (w_accept) begin
                    r_betMode  <= w_mode;
                    r_betGuess <= io_bus.bet_guess;
                    r_betAmt   <= io_bus.bet_amt;
                    r_spinCnt  <= CNT_W'(1);
                end else if ((r_state == ST_SPIN) && (r_spinCnt < CNT_W'(SPIN_CYCLES))) begin
                    r_spinCnt <= r_spinCnt + CNT_W'(1);
                end
                if (w_spinDone) begin
                    r_spinNum <= w_candidate;
                end
                if (r_state == ST_SETTLE) begin
                    r_balance     <= w_newBalance;
                    r_resultNum   <= r_spinNum;
                    r_resultWin   <= w_win;
                    r_resultValid <= 1'b1;
                end
            end
        end
    end

    assign io_bus.bet_ready    = w_betReady;
    assign io_bus.bet_err      = r_betErr;
    assign io_bus.result_valid = r_resultValid;
    assign io_bus.result_num   = r_resultNum;
    assign io_bus.result_win   = r_resultWin;
    assign io_bus.balance      = r_balance;
    assign io_bus.game_won     = (r_state == ST_WON);
    assign io_bus.game_lost    = (r_state == ST_LOST);

endmodule

// File: tb/tb_roulette_engine.sv
// tb_roulette_engine: directed bench for roulette_engine. Instance A (wheel
// 0..31) is driven with external numbers and hand-computed balances; instance
// B (wheel 0..20) runs on its LFSR and is checked against a parity model.
module tb_roulette_engine;
    import roulette_pkg::*;

`ifdef ROULETTE_STREAK_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   checkCount = 0;
    int   failCount  = 0;

    roulette_if #(.NUM_W(5), .AMT_W(4), .BAL_W(8)) busA ();
    roulette_if #(.NUM_W(5), .AMT_W(4), .BAL_W(8)) busB ();

    roulette_engine dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (busA)
    );

    roulette_engine #(.NUM_MAX(20)) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one bet on A at a negedge; returns at the next negedge
    task automatic applyStimulus(input bet_mode_t mode, input logic [4:0] guess,
                                 input logic [3:0] amt, input logic [4:0] extNum);
        busA.ext_num_en = 1'b1;
        busA.ext_num    = extNum;
        busA.bet_mode   = mode;
        busA.bet_guess  = guess;
        busA.bet_amt    = amt;
        busA.bet_valid  = 1'b1;
        @(negedge clk);
        busA.bet_valid  = 1'b0;
    endtask

    task automatic waitResultA(output int lat);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busA.result_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulseStartA();
        busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
    endtask

    task automatic playA(input string tag, input bet_mode_t mode, input logic [4:0] guess,
                         input logic [3:0] amt, input logic [4:0] extNum,
                         input int expBal, input int expWin, input int expStreak);
        int lat;
        applyStimulus(mode, guess, amt, extNum);
        waitResultA(lat);
        checkOutput({tag, "Latency"}, lat, 10);
        checkOutput({tag, "Win"}, busA.result_win, expWin);
        checkOutput({tag, "Num"}, busA.result_num, extNum);
        checkOutput({tag, "Bal"}, busA.balance, expBal);
        checkOutput({tag, "Streak"}, busA.streak, expStreak);
    endtask

    task automatic checkRejectA(input string tag);
        checkOutput({tag, "Err"}, busA.bet_err, 1);
        checkOutput({tag, "Bal"}, busA.balance, 10);
        checkOutput({tag, "Ready"}, busA.bet_ready, 1);
        @(negedge clk);
        checkOutput({tag, "ErrPulse"}, busA.bet_err, 0);
    endtask

    initial begin
        int        lat;
        int        spins;
        int        cycles;
        int        maxNum;
        int        minLat;
        int        badModel;
        int        prevBal;
        int        expBal;
        logic      expWin;
        logic      sawValid;
        logic [4:0] num;
        bet_mode_t modeB;

        busA.start = 0; busA.abort = 0; busA.bet_valid = 0; busA.bet_mode = 0;
        busA.bet_guess = 0; busA.bet_amt = 0; busA.ext_num_en = 0; busA.ext_num = 0;
        busB.start = 0; busB.abort = 0; busB.bet_valid = 0; busB.bet_mode = 0;
        busB.bet_guess = 0; busB.bet_amt = 0; busB.ext_num_en = 0; busB.ext_num = 0;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBalance", busA.balance, 0);
        checkOutput("rstReady", busA.bet_ready, 0);
        checkOutput("rstResultNum", busA.result_num, 0);
        checkOutput("rstResultWin", busA.result_win, 0);
        checkOutput("rstResultValid", busA.result_valid, 0);
        checkOutput("rstBetErr", busA.bet_err, 0);
        checkOutput("rstWon", busA.game_won, 0);
        checkOutput("rstLost", busA.game_lost, 0);
        checkOutput("rstStreak", busA.streak, 0);
        checkOutput("rstBalanceB", busB.balance, 0);
        reset_n = 1'b1;
        @(negedge clk);

        pulseStartA();
        checkOutput("startBal", busA.balance, 10);
        checkOutput("startReady", busA.bet_ready, 1);
        checkOutput("startWon", busA.game_won, 0);
        checkOutput("startResultValid", busA.result_valid, 0);

        playA("exact7", MODE_EXACT, 5'd7, 4'd2, 5'd7, 18, 1, BONUS_ON ? 1 : 0);
        checkOutput("readyLowAtResult", busA.bet_ready, 0);
        @(negedge clk);
        checkOutput("readyAfterResult", busA.bet_ready, 1);
        checkOutput("validOnePulse", busA.result_valid, 0);

        playA("exact7b", MODE_EXACT, 5'd7, 4'd1, 5'd7, 22, 1, BONUS_ON ? 2 : 0);
        checkOutput("wonFlag", busA.game_won, 1);
        @(negedge clk);
        checkOutput("wonNoReady", busA.bet_ready, 0);

        pulseStartA();
        checkOutput("restartBal", busA.balance, 10);
        checkOutput("restartWonClr", busA.game_won, 0);

        playA("evenZero", MODE_EVEN, 5'd0, 4'd3, 5'd0, 7, 0, 0);
        @(negedge clk);
        playA("oddFour", MODE_ODD, 5'd0, 4'd7, 5'd4, 0, 0, 0);
        checkOutput("lostFlag", busA.game_lost, 1);
        checkOutput("lostNoReady", busA.bet_ready, 0);

        pulseStartA();
        checkOutput("restart2Bal", busA.balance, 10);
        checkOutput("restart2LostClr", busA.game_lost, 0);

        applyStimulus(MODE_EXACT, 5'd3, 4'd11, 5'd3);
        checkRejectA("rejAmtOver");
        applyStimulus(MODE_RSVD, 5'd0, 4'd1, 5'd0);
        checkRejectA("rejMode3");
        applyStimulus(MODE_ODD, 5'd0, 4'd0, 5'd1);
        checkRejectA("rejAmtZero");

        playA("oddWin", MODE_ODD, 5'd0, 4'd2, 5'd3, 12, 1, BONUS_ON ? 1 : 0);
        @(negedge clk);
        playA("even31", MODE_EVEN, 5'd0, 4'd2, 5'd31, 10, 0, 0);
        @(negedge clk);

        applyStimulus(MODE_EXACT, 5'd1, 4'd1, 5'd1);
        repeat (2) @(negedge clk);
        busA.abort = 1'b1;
        busA.start = 1'b1;
        @(negedge clk);
        busA.abort = 1'b0;
        busA.start = 1'b0;
        checkOutput("abortBal", busA.balance, 0);
        checkOutput("abortReady", busA.bet_ready, 0);
        checkOutput("abortWon", busA.game_won, 0);
        checkOutput("abortLost", busA.game_lost, 0);
        checkOutput("abortStreak", busA.streak, 0);
        sawValid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (busA.result_valid) sawValid = 1'b1;
            @(negedge clk);
        end
        checkOutput("abortNoResult", sawValid, 0);
        checkOutput("abortStaysIdle", busA.bet_ready, 0);

        pulseStartA();
        playA("streak1", MODE_EXACT, 5'd5, 4'd1, 5'd5, 14, 1, BONUS_ON ? 1 : 0);
        @(negedge clk);
        playA("streak2", MODE_EXACT, 5'd5, 4'd1, 5'd5, 18, 1, BONUS_ON ? 2 : 0);
        @(negedge clk);
        playA("streak3", MODE_EXACT, 5'd5, 4'd1, 5'd5, BONUS_ON ? 27 : 22, 1, 0);
        checkOutput("streakWon", busA.game_won, 1);

        // Instance B: wheel 0..20
        busB.start = 1'b1;
        @(negedge clk);
        busB.start = 1'b0;
        checkOutput("bStartBal", busB.balance, 10);
        busB.ext_num_en = 1'b1;
        busB.ext_num    = 5'd20;
        busB.bet_mode   = MODE_EXACT;
        busB.bet_guess  = 5'd25;
        busB.bet_amt    = 4'd1;
        busB.bet_valid  = 1'b1;
        @(negedge clk);
        busB.bet_valid  = 1'b0;
        checkOutput("bRejGuess", busB.bet_err, 1);
        busB.bet_guess  = 5'd20;
        busB.bet_valid  = 1'b1;
        @(negedge clk);
        busB.bet_valid  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busB.result_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checkOutput("bEdgeLatency", lat, 10);
        checkOutput("bEdgeWin", busB.result_win, 1);
        checkOutput("bEdgeBal", busB.balance, 14);

        busB.ext_num_en = 1'b0;
        busB.bet_amt    = 4'd1;
        spins = 0; cycles = 0; maxNum = 0; minLat = 1000; badModel = 0;
        while (spins < 1000 && cycles < 40000) begin
            if (busB.game_won || busB.game_lost) begin
                busB.start = 1'b1;
                @(negedge clk);
                busB.start = 1'b0;
                cycles++;
            end else if (busB.bet_ready) begin
                prevBal = busB.balance;
                modeB = spins[0] ? MODE_ODD : MODE_EVEN;
                busB.bet_mode  = modeB;
                busB.bet_valid = 1'b1;
                @(negedge clk);
                busB.bet_valid = 1'b0;
                cycles++;
                lat = 0;
                for (int k = 1; k <= 200; k++) begin
                    if (busB.result_valid) begin
                        lat = k;
                        break;
                    end
                    @(negedge clk);
                    cycles++;
                end
                if (lat == 0) break;
                spins++;
                num = busB.result_num;
                if (int'(num) > maxNum) maxNum = int'(num);
                if (lat < minLat) minLat = lat;
                expWin = (modeB == MODE_EVEN) ? ((num != 5'd0) && !num[0]) : num[0];
                expBal = expWin ? prevBal + 1 : prevBal - 1;
                if ((busB.result_win !== expWin) || (int'(busB.balance) != expBal)) badModel++;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        checkOutput("lfsrSpinCount", spins, 1000);
        checkOutput("lfsrMaxInRange", (maxNum <= 20), 1);
        checkOutput("lfsrMinLatency", (minLat >= 10), 1);
        checkOutput("lfsrBalanceModel", badModel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
